// File: rtl/wb_grf_unit.sv
// W-stage consumer: instruction decode, write-back select/extend,
// general register file with bypassed read ports, and retire counter.
module wb_grf_unit #(
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        movnW,
  input  logic        movzW,
  input  logic [4:0]  WriteRegW,
  input  logic [31:0] InstrutionW,
  input  logic [31:0] PCouter8W,
  input  logic [31:0] ReadDataW,
  input  logic [31:0] ALUOutW,
  input  logic [31:0] HiDataW,
  input  logic [31:0] LoDataW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic [31:0] retired,
  output logic [31:0] trace_pc_off
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_MOVZ = 6'b001010;
  localparam logic [5:0] FN_MOVN = 6'b001011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic        is_special;
  logic        is_link;
  logic        is_mfhi;
  logic        is_mflo;
  logic        is_load;
  logic        rw;
  logic [31:0] load_val;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] grf [32];

  assign op         = InstrutionW[31:26];
  assign funct      = InstrutionW[5:0];
  assign is_special = (op == OP_SPECIAL);
  assign is_link    = (op == OP_JAL) || (is_special && funct == FN_JALR);
  assign is_mfhi    = is_special && (funct == FN_MFHI);
  assign is_mflo    = is_special && (funct == FN_MFLO);
  assign is_load    = (op == OP_LW) || (op == OP_LB) || (op == OP_LBU)
                   || (op == OP_LH) || (op == OP_LHU);

  // Register-write decode; conditional moves gated by upstream flags
  always_comb begin
    rw = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV,
          FN_SRLV, FN_SRAV, FN_ADD, FN_SUB, FN_JALR,
          FN_MFHI, FN_MFLO: rw = 1'b1;
          FN_MOVN:          rw = movnW;
          FN_MOVZ:          rw = movzW;
          default:          rw = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_SLTI, OP_SLTIU:          rw = 1'b1;
      OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: rw = 1'b1;
      OP_JAL:                             rw = 1'b1;
      default:                            rw = 1'b0;
    endcase
  end

  // Load lane pick and sign/zero extension; off[0] ignored for halves
  always_comb begin
    ld_byte  = ReadDataW[8*ALUOutW[1:0] +: 8];
    ld_half  = ALUOutW[1] ? ReadDataW[31:16] : ReadDataW[15:0];
    load_val = ReadDataW;
    case (op)
      OP_LB:   load_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  load_val = {24'h0, ld_byte};
      OP_LH:   load_val = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  load_val = {16'h0, ld_half};
      default: load_val = ReadDataW;
    endcase
  end

  // Write-back value select
  always_comb begin
    wb_data = ALUOutW;
    unique case (1'b1)
      is_link: wb_data = PCouter8W;
      is_mfhi: wb_data = HiDataW;
      is_mflo: wb_data = LoDataW;
      is_load: wb_data = load_val;
      default: wb_data = ALUOutW;
    endcase
  end

  assign wb_we   = rw && (WriteRegW != 5'd0);
  assign wb_addr = WriteRegW;

  // Register file storage; $0 never written since wb_we excludes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'h0;
    end else if (wb_we) begin
      grf[wb_addr] <= wb_data;
    end
  end

  // Retire counter: any non-NOP word in W counts, wraps naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired <= 32'h0;
    else if (InstrutionW != 32'h0) retired <= retired + 32'd1;
  end

  assign RD1 = (A1 == 5'd0) ? 32'h0 :
               (wb_we && A1 == wb_addr) ? wb_data : grf[A1];
  assign RD2 = (A2 == 5'd0) ? 32'h0 :
               (wb_we && A2 == wb_addr) ? wb_data : grf[A2];

  assign trace_pc_off = PCouter8W - 32'd8 - RESET_PC_TAG;

endmodule

// File: tb/tb_wb_grf_unit.sv
// Directed bench for wb_grf_unit: reset, loads, moves, links,
// bypass, $0 handling and the retire counter.
module tb_wb_grf_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        movnW, movzW;
  logic [4:0]  WriteRegW;
  logic [31:0] InstrutionW, PCouter8W, ReadDataW, ALUOutW;
  logic [31:0] HiDataW, LoDataW;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, wb_data, retired, trace_pc_off;
  logic        wb_we;
  logic [4:0]  wb_addr;

  int n_cmp = 0;
  int n_bad = 0;

  wb_grf_unit dut (
    .clk(clk), .reset(reset), .movnW(movnW), .movzW(movzW),
    .WriteRegW(WriteRegW), .InstrutionW(InstrutionW),
    .PCouter8W(PCouter8W), .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
    .HiDataW(HiDataW), .LoDataW(LoDataW), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .retired(retired), .trace_pc_off(trace_pc_off)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0004};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    InstrutionW = 32'h0;
    WriteRegW   = 5'd0;
    movnW       = 1'b0;
    movzW       = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle();
    PCouter8W = 32'h0; ReadDataW = 32'h0; ALUOutW = 32'h0;
    HiDataW = 32'h0; LoDataW = 32'h0; A1 = 5'd5; A2 = 5'd5;
    #2;
    n_cmp++;
    if (wb_we !== 1'b0 || wb_addr !== 5'd0 || wb_data !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%h, want 0/0/0",
               wb_we, wb_addr, wb_data);
    end
    n_cmp++;
    if (RD1 !== 32'h0 || RD2 !== 32'h0 || retired !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_reads: RD1=%h RD2=%h ret=%h, want 0",
               RD1, RD2, retired);
    end
    tick();
    reset = 1'b0;
    InstrutionW = rtype(6'b100001);
    WriteRegW = 5'd5; ALUOutW = 32'd1;
    tick();
    ALUOutW = 32'd7;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (dut.grf[5] !== 32'h0 || retired !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_async: grf5=%h ret=%h, want 0/0",
               dut.grf[5], retired);
    end
    tick();
    idle();
    reset = 1'b0;
    tick();
    A1 = 5'd5;
    #1;
    n_cmp++;
    if (RD1 !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_discard: RD1=%h, want 0", RD1);
    end
  endtask

  task automatic test_loads;
    logic [5:0]  ops [6];
    logic [31:0] alu [6];
    logic [31:0] exp [6];
    ops = '{6'b100000, 6'b100100, 6'b100001, 6'b100101, 6'b100011, 6'b100100};
    alu = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h103};
    exp = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_80F0, 32'h0000_80F0,
            32'h80F0_1234, 32'h0000_0080};
    ReadDataW = 32'h80F0_1234;
    for (int i = 0; i < 6; i++) begin
      InstrutionW = itype(ops[i]);
      WriteRegW = 5'd8;
      ALUOutW = alu[i];
      tick();
      idle();
      A1 = 5'd8;
      #1;
      n_cmp++;
      if (RD1 !== exp[i]) begin
        n_bad++;
        $display("FAIL load_%0d: grf8=%h, want %h", i, RD1, exp[i]);
      end
    end
  endtask

  task automatic test_cond_moves;
    InstrutionW = itype(6'b001101);
    WriteRegW = 5'd9; ALUOutW = 32'h11;
    tick();
    InstrutionW = rtype(6'b001011);
    ALUOutW = 32'h55; movnW = 1'b0;
    #1;
    n_cmp++;
    if (wb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL movn_false_we: we=%b, want 0", wb_we);
    end
    tick();
    idle(); A1 = 5'd9;
    #1;
    n_cmp++;
    if (RD1 !== 32'h11) begin
      n_bad++;
      $display("FAIL movn_false_keep: grf9=%h, want 11", RD1);
    end
    InstrutionW = rtype(6'b001011);
    WriteRegW = 5'd9; movnW = 1'b1;
    tick();
    idle();
    #1;
    n_cmp++;
    if (RD1 !== 32'h55) begin
      n_bad++;
      $display("FAIL movn_true: grf9=%h, want 55", RD1);
    end
    InstrutionW = itype(6'b001101);
    WriteRegW = 5'd9; ALUOutW = 32'h11;
    tick();
    InstrutionW = rtype(6'b001010);
    ALUOutW = 32'h55; movzW = 1'b0; movnW = 1'b1;
    #1;
    n_cmp++;
    if (wb_we !== 1'b0) begin
      n_bad++;
      $display("FAIL movz_false_we: we=%b, want 0", wb_we);
    end
    movzW = 1'b1; movnW = 1'b0;
    tick();
    idle();
    #1;
    n_cmp++;
    if (RD1 !== 32'h55) begin
      n_bad++;
      $display("FAIL movz_true: grf9=%h, want 55", RD1);
    end
  endtask

  task automatic test_link_hilo;
    PCouter8W = 32'h3008; ALUOutW = 32'hAAAA;
    InstrutionW = {6'b000011, 26'h0000C02};
    WriteRegW = 5'd31;
    #1;
    n_cmp++;
    if (trace_pc_off !== 32'h0) begin
      n_bad++;
      $display("FAIL trace_pc0: off=%h, want 0", trace_pc_off);
    end
    tick();
    InstrutionW = rtype(6'b001001);
    WriteRegW = 5'd4;
    tick();
    idle(); A1 = 5'd31; A2 = 5'd4;
    #1;
    n_cmp++;
    if (RD1 !== 32'h3008 || RD2 !== 32'h3008) begin
      n_bad++;
      $display("FAIL link: jal=%h jalr=%h, want 3008", RD1, RD2);
    end
    HiDataW = 32'h1111_2222; LoDataW = 32'h3333_4444;
    InstrutionW = rtype(6'b010000); WriteRegW = 5'd10;
    tick();
    InstrutionW = rtype(6'b010010); WriteRegW = 5'd11;
    tick();
    idle(); A1 = 5'd10; A2 = 5'd11; PCouter8W = 32'h3100;
    #1;
    n_cmp++;
    if (RD1 !== 32'h1111_2222 || RD2 !== 32'h3333_4444) begin
      n_bad++;
      $display("FAIL hilo: hi=%h lo=%h, want 11112222/33334444", RD1, RD2);
    end
    n_cmp++;
    if (trace_pc_off !== 32'hF8) begin
      n_bad++;
      $display("FAIL trace_pc: off=%h, want f8", trace_pc_off);
    end
  endtask

  task automatic test_bypass_zero;
    InstrutionW = itype(6'b001101);
    WriteRegW = 5'd3; ALUOutW = 32'hDEAD;
    A1 = 5'd3; A2 = 5'd3;
    #1;
    n_cmp++;
    if (RD1 !== 32'hDEAD || RD2 !== 32'hDEAD) begin
      n_bad++;
      $display("FAIL bypass: RD1=%h RD2=%h, want dead", RD1, RD2);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (RD1 !== 32'hDEAD) begin
      n_bad++;
      $display("FAIL bypass_store: grf3=%h, want dead", RD1);
    end
    InstrutionW = itype(6'b001101);
    WriteRegW = 5'd0; ALUOutW = 32'h77; A1 = 5'd0;
    #1;
    n_cmp++;
    if (wb_we !== 1'b0 || RD1 !== 32'h0) begin
      n_bad++;
      $display("FAIL zero_reg: we=%b RD1=%h, want 0/0", wb_we, RD1);
    end
    tick();
    n_cmp++;
    if (RD1 !== 32'h0 || dut.grf[0] !== 32'h0) begin
      n_bad++;
      $display("FAIL zero_store: RD1=%h grf0=%h, want 0", RD1, dut.grf[0]);
    end
  endtask

  task automatic test_counter;
    logic [31:0] seq [8];
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    seq = '{rtype(6'b100001), itype(6'b001101), itype(6'b100011),
            rtype(6'b001011), itype(6'b000100), 32'h0, 32'h0,
            itype(6'b101011)};
    for (int i = 0; i < 8; i++) begin
      InstrutionW = seq[i];
      WriteRegW = 5'd12;
      if (i == 7) begin
        #1;
        n_cmp++;
        if (wb_we !== 1'b0) begin
          n_bad++;
          $display("FAIL sw_we: we=%b, want 0", wb_we);
        end
      end
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if (retired !== 32'd6) begin
      n_bad++;
      $display("FAIL retired_count: ret=%0d, want 6", retired);
    end
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    #1;
    InstrutionW = itype(6'b001001);
    tick();
    idle();
    n_cmp++;
    if (retired !== 32'h0) begin
      n_bad++;
      $display("FAIL retired_wrap: ret=%h, want 0", retired);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_cond_moves();
    test_link_hilo();
    test_bypass_zero();
    test_counter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
